// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default
// source count and the fixed-priority encoder.
package intr_pkg;

  localparam int N_SRC_DEF = 4;
  localparam int MAX_SRC   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_INSERV = 2'd2
  } state_t;

  // Lowest set index wins; scanning downward lets the last hit be the lowest.
  function automatic logic [2:0] prio_enc(input logic [MAX_SRC-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = MAX_SRC - 1; k >= 0; k--) begin
      if (vec[k]) begin
        idx = 3'(k);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one raw interrupt line, followed by a rising-edge
// detector producing a single-cycle pulse.
module irq_sync_edge (
  input  logic sys_clk,
  input  logic reset,
  input  logic irq_async,
  output logic edge_pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus one delayed copy for edge comparison.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= irq_async;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign edge_pulse = sync_r & ~prev_r;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask, fixed-priority
// selection and a request/service handshake with the control unit.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic             mask_ld,
  input  logic [N_SRC-1:0] mask_in,
  input  logic             INT_ACK,
  input  logic             eoi,
  output logic             INTR,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic             in_service
);

  logic [N_SRC-1:0]   edge_s;
  logic [N_SRC-1:0]   mask_r;
  logic [N_SRC-1:0]   pending_r;
  logic [N_SRC-1:0]   pending_nxt_s;
  logic [N_SRC-1:0]   eligible_s;
  logic [N_SRC-1:0]   clear_s;
  logic [MAX_SRC-1:0] elig_ext_s;
  logic [ID_W-1:0]    irq_id_r;
  logic [ID_W-1:0]    irq_id_nxt_s;
  logic               intr_r;
  logic               in_service_r;
  state_t             state_r;
  state_t             state_nxt_s;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .irq_async  (irq[g]),
      .edge_pulse (edge_s[g])
    );
  end

  // Next-state, id latch and pending-clear decode.
  always_comb begin
    state_nxt_s  = state_r;
    irq_id_nxt_s = irq_id_r;
    clear_s      = '0;
    eligible_s   = pending_r & mask_r;
    elig_ext_s   = '0;
    elig_ext_s[N_SRC-1:0] = eligible_s;
    case (state_r)
      ST_IDLE: begin
        if (|eligible_s) begin
          state_nxt_s  = ST_REQ;
          irq_id_nxt_s = ID_W'(prio_enc(elig_ext_s));
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (INT_ACK) begin
          state_nxt_s        = ST_INSERV;
          clear_s[irq_id_r]  = 1'b1;
        end else begin
          state_nxt_s        = ST_REQ;
        end
      end
      ST_INSERV: begin
        if (eoi) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_INSERV;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // A fresh edge overrides the acknowledge clear of the same bit.
    pending_nxt_s = (pending_r & ~clear_s) | edge_s;
  end

  // FSM state, selected id and registered request/service outputs.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      irq_id_r     <= '0;
      intr_r       <= 1'b0;
      in_service_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      irq_id_r     <= irq_id_nxt_s;
      intr_r       <= (state_nxt_s == ST_REQ);
      in_service_r <= (state_nxt_s == ST_INSERV);
    end
  end

  // Mask register and pending vector.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      mask_r    <= '0;
      pending_r <= '0;
    end else begin
      pending_r <= pending_nxt_s;
      if (mask_ld) begin
        mask_r <= mask_in;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  assign INTR       = intr_r;
  assign irq_id     = irq_id_r;
  assign pending    = pending_r;
  assign in_service = in_service_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Randomized and directed bench for intr_ctrl with a cycle-level reference
// model feeding a scoreboard of expected output snapshots and grants.
module tb_intr_ctrl;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b0;
  logic [3:0] irq     = 4'h0;
  logic       mask_ld = 1'b0;
  logic [3:0] mask_in = 4'h0;
  logic       INT_ACK = 1'b0;
  logic       eoi     = 1'b0;
  logic       INTR;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic       in_service;

  intr_ctrl #(.N_SRC(4)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .irq        (irq),
    .mask_ld    (mask_ld),
    .mask_in    (mask_in),
    .INT_ACK    (INT_ACK),
    .eoi        (eoi),
    .INTR       (INTR),
    .irq_id     (irq_id),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 sys_clk = ~sys_clk;

  typedef enum int {M_IDLE, M_REQ, M_SERV} mst_t;
  typedef struct packed {
    logic       intr;
    logic [1:0] id;
    logic [3:0] pend;
    logic       insvc;
  } snap_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  mst_t       m_st     = M_IDLE;
  logic [3:0] m_pend   = 4'h0;
  logic [3:0] m_mask   = 4'h0;
  int         m_id     = 0;
  logic [3:0] hist[$];
  snap_t      snap_q[$];
  int         grant_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference: a rise seen in the samples two edges ago becomes pending now.
  task automatic step_model(input logic rst_v, input logic [3:0] irq_v,
                            input logic ml, input logic [3:0] mi,
                            input logic ack, input logic e);
    logic [3:0] rises;
    logic [3:0] clr;
    logic [3:0] elig;
    snap_t      s;
    if (!rst_v) begin
      m_st   = M_IDLE;
      m_pend = 4'h0;
      m_mask = 4'h0;
      m_id   = 0;
      hist   = '{4'h0, 4'h0, 4'h0, 4'h0};
    end else begin
      hist.push_front(irq_v);
      hist.delete(4);
      rises = hist[2] & ~hist[3];
      clr   = 4'h0;
      elig  = m_pend & m_mask;
      case (m_st)
        M_IDLE: if (elig != 4'h0) begin
          m_id = lowest(elig);
          m_st = M_REQ;
          grant_q.push_back(m_id);
        end
        M_REQ: if (ack) begin
          clr[m_id] = 1'b1;
          m_st = M_SERV;
        end
        default: if (e) m_st = M_IDLE;
      endcase
      m_pend = (m_pend & ~clr) | rises;
      if (ml) m_mask = mi;
    end
    s.intr  = (m_st == M_REQ);
    s.id    = 2'(m_id);
    s.pend  = m_pend;
    s.insvc = (m_st == M_SERV);
    snap_q.push_back(s);
  endtask

  task automatic cyc(input logic [3:0] irq_v, input logic ack = 1'b0,
                     input logic e = 1'b0, input logic ml = 1'b0,
                     input logic [3:0] mi = 4'h0, input logic rst_v = 1'b1);
    @(negedge sys_clk);
    irq = irq_v; INT_ACK = ack; eoi = e; mask_ld = ml; mask_in = mi; reset = rst_v;
    @(posedge sys_clk);
    #1;
    step_model(rst_v, irq_v, ml, mi, ack, e);
  endtask

  task automatic wait_req(input logic [3:0] irq_v);
    for (int i = 0; i < 20 && m_st != M_REQ; i++) cyc(irq_v);
    check("reach_req_bound", int'(m_st == M_REQ), 1);
  endtask

  // Monitor: compare each expected snapshot and each new request against the DUT.
  logic  intr_q = 1'b0;
  snap_t cur;
  initial begin
    forever begin
      @(negedge sys_clk);
      if (snap_q.size() > 0) begin
        cur = snap_q.pop_front();
        check("INTR", int'(INTR), int'(cur.intr));
        check("irq_id", int'(irq_id), int'(cur.id));
        check("pending", int'(pending), int'(cur.pend));
        check("in_service", int'(in_service), int'(cur.insvc));
      end
      if (INTR && !intr_q) begin
        if (grant_q.size() == 0) begin
          check("grant_unexpected", 1, 0);
        end else begin
          check("grant_id", int'(irq_id), grant_q.pop_front());
        end
      end
      intr_q = INTR;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected end of test");
    $fatal(1, "timeout");
  end

  logic [3:0] irq_cur;
  initial begin
    hist = '{4'h0, 4'h0, 4'h0, 4'h0};
    irq  = 4'hF;
    // Reset with every line high: nothing visible until release, then all pending, no request.
    repeat (3) cyc(4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (12) cyc(4'hF);
    repeat (2) cyc(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (3) cyc(4'h0);

    // Single unmasked source, full request/ack/eoi sequence.
    cyc(4'h0, 1'b0, 1'b0, 1'b1, 4'b0100);
    wait_req(4'b0100);
    check("id_src2", int'(m_id), 2);
    cyc(4'b0100, 1'b1);
    repeat (2) cyc(4'b0100);
    cyc(4'b0100, 1'b0, 1'b1);
    repeat (2) cyc(4'h0);

    // Simultaneous edges on 3 and 1: 1 first, 3 after one idle cycle.
    cyc(4'h0, 1'b0, 1'b0, 1'b1, 4'hF);
    wait_req(4'b1010);
    cyc(4'b1010, 1'b1);
    cyc(4'b1010, 1'b0, 1'b1);
    cyc(4'b1010);
    wait_req(4'b1010);
    cyc(4'b1010, 1'b1);
    cyc(4'b1010, 1'b0, 1'b1);
    repeat (3) cyc(4'h0);

    // Re-edge on source 1 landing exactly on its acknowledge clear.
    wait_req(4'b0010);
    repeat (2) cyc(4'h0);
    repeat (2) cyc(4'b0010);
    cyc(4'b0010, 1'b1);
    cyc(4'b0010);
    cyc(4'b0010, 1'b0, 1'b1);
    wait_req(4'b0010);
    cyc(4'b0010, 1'b1);
    cyc(4'b0010, 1'b0, 1'b1);
    repeat (2) cyc(4'h0);

    // Stray ack/eoi in IDLE, eoi during REQ.
    cyc(4'h0, 1'b1, 1'b0);
    cyc(4'h0, 1'b0, 1'b1);
    cyc(4'h0, 1'b1, 1'b1);
    wait_req(4'b1000);
    cyc(4'b1000, 1'b0, 1'b1);
    cyc(4'b1000);
    cyc(4'b1000, 1'b1);
    cyc(4'b1000);

    // Asynchronous reset while in service.
    @(negedge sys_clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_INTR", int'(INTR), 0);
    check("async_rst_irq_id", int'(irq_id), 0);
    check("async_rst_pending", int'(pending), 0);
    check("async_rst_in_service", int'(in_service), 0);
    repeat (2) cyc(4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (5) cyc(4'h0);

    // Randomized traffic.
    cyc(4'h0, 1'b0, 1'b0, 1'b1, 4'($urandom_range(1, 15)));
    irq_cur = 4'h0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) irq_cur = irq_cur ^ (4'b0001 << $urandom_range(0, 3));
      cyc(irq_cur, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
    end
    repeat (3) cyc(4'h0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("grant_queue_drained", grant_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
